// File: rtl/pwm_note_sequencer_if.sv
// Note command channel for the PWM note sequencer.
// Valid/ready handshake carrying a phase step and a duration.
interface pwm_note_sequencer_if #(
  parameter int PHASE_W = 24,
  parameter int DUR_W   = 16
) ();
  logic               cmd_valid;
  logic               cmd_ready;
  logic [PHASE_W-1:0] cmd_phase_inc;
  logic [DUR_W-1:0]   cmd_duration;

  modport master (
    output cmd_valid,
    output cmd_phase_inc,
    output cmd_duration,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_phase_inc,
    input  cmd_duration,
    output cmd_ready
  );
endinterface

// File: rtl/pwm_note_sequencer.sv
// Queued note player driving the PWM stage voltage word.
// Prescaled phase accumulator, triangle shaping, silent gaps.
module pwm_note_sequencer #(
  parameter int NBITRES     = 12,
  parameter int PRESCALE    = 1024,
  parameter int PHASE_W     = 24,
  parameter int DUR_W       = 16,
  parameter int FIFO_DEPTH  = 4,
  parameter int GAP_SAMPLES = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  pwm_note_sequencer_if.slave  cmd,
  input  logic                 flush,
  output logic [NBITRES-1:0]   ubit_voltage,
  output logic                 sample_strobe,
  output logic                 busy,
  output logic                 note_done
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int GW = $clog2(GAP_SAMPLES + 2);

  localparam logic [PW-1:0] P_LAST = PW'(PRESCALE - 1);
  localparam logic [CW-1:0] FULL_N = CW'(FIFO_DEPTH);
  localparam logic [GW-1:0] G_LAST = GW'(GAP_SAMPLES - 1);
  localparam logic [NBITRES-1:0] MID =
    {1'b1, {(NBITRES-1){1'b0}}};

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_PLAY = 2'd2;
  localparam logic [1:0] S_GAP  = 2'd3;
  localparam logic [1:0] S_POST =
    (GAP_SAMPLES == 0) ? S_IDLE : S_GAP;

  logic [1:0]         state;
  logic [PW-1:0]      pcnt;
  logic [PHASE_W-1:0] acc;
  logic [PHASE_W-1:0] inc_reg;
  logic [DUR_W-1:0]   remaining;
  logic [GW-1:0]      gcnt;

  logic [PHASE_W-1:0] inc_mem [FIFO_DEPTH];
  logic [DUR_W-1:0]   dur_mem [FIFO_DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [CW-1:0]      count;
  logic               full;
  logic               empty;
  logic               push;
  logic               pop;

  logic [NBITRES:0]   p;
  logic [NBITRES-1:0] tri_v;

  assign full  = (count == FULL_N);
  assign empty = (count == '0);
  assign push  = cmd.cmd_valid & cmd.cmd_ready;
  assign pop   = (state == S_LOAD);
  assign busy  = (state != S_IDLE);

  assign cmd.cmd_ready = rst_n & ~flush & ~full;

  assign p     = acc[PHASE_W-1 -: NBITRES+1];
  assign tri_v = p[NBITRES] ? ~p[NBITRES-1:0]
                            : p[NBITRES-1:0];

  // Free-running sample-rate prescaler and strobe
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pcnt          <= '0;
      sample_strobe <= 1'b0;
    end else begin
      sample_strobe <= (pcnt == P_LAST);
      pcnt <= (pcnt == P_LAST) ? '0 : pcnt + 1'b1;
    end
  end

  // Command queue storage, written on accepted pushes
  always_ff @(posedge clk) begin
    if (push) begin
      inc_mem[wr_ptr] <= cmd.cmd_phase_inc;
      dur_mem[wr_ptr] <= cmd.cmd_duration;
    end
  end

  // Queue pointers and occupancy
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case (1'b1)
        push && !pop: count <= count + 1'b1;
        pop && !push: count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // Note player: load, play per strobe, gap, idle
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      state        <= S_IDLE;
      acc          <= '0;
      inc_reg      <= '0;
      remaining    <= '0;
      gcnt         <= '0;
      ubit_voltage <= MID;
      note_done    <= 1'b0;
    end else begin
      note_done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          ubit_voltage <= MID;
          if (!empty) state <= S_LOAD;
        end
        S_LOAD: begin
          inc_reg   <= inc_mem[rd_ptr];
          remaining <= dur_mem[rd_ptr];
          acc       <= '0;
          gcnt      <= '0;
          if (dur_mem[rd_ptr] == '0) begin
            note_done <= 1'b1;
            state     <= S_POST;
          end else begin
            state <= S_PLAY;
          end
        end
        S_PLAY: begin
          if (sample_strobe) begin
            ubit_voltage <= (inc_reg == '0) ? MID : tri_v;
            acc       <= acc + inc_reg;
            remaining <= remaining - 1'b1;
            if (remaining == DUR_W'(1)) begin
              note_done <= 1'b1;
              state     <= S_POST;
            end
          end
        end
        S_GAP: begin
          if (sample_strobe) begin
            ubit_voltage <= MID;
            if (gcnt == G_LAST) begin
              state <= empty ? S_IDLE : S_LOAD;
            end else begin
              gcnt <= gcnt + 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_note_sequencer.sv
// Directed bench for pwm_note_sequencer.
// Small parameters; expectations computed by hand.
module tb_pwm_note_sequencer;

  localparam int NB = 4;
  localparam int PW = 8;
  localparam int PS = 4;
  localparam int FD = 4;
  localparam int GS = 2;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic [NB-1:0] ubit;
  logic          strobe;
  logic          busy;
  logic          note_done;

  int errs = 0;
  int checks = 0;
  int done_cnt = 0;
  int done_log[$];

  pwm_note_sequencer_if #(.PHASE_W(PW), .DUR_W(DW)) cif ();

  pwm_note_sequencer #(
    .NBITRES(NB), .PRESCALE(PS), .PHASE_W(PW),
    .DUR_W(DW), .FIFO_DEPTH(FD), .GAP_SAMPLES(GS)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .cmd(cif.slave),
    .flush(flush),
    .ubit_voltage(ubit),
    .sample_strobe(strobe),
    .busy(busy),
    .note_done(note_done)
  );

  always #5 clk = ~clk;

  // Record every note_done pulse and the voltage it ends on
  always @(negedge clk) begin
    if (note_done === 1'b1) begin
      done_cnt++;
      done_log.push_back(int'(ubit));
    end
  end

  task automatic chk(input string tag, input int obs,
                     input int exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errs++;
      $error("FAIL %s: observed=%0d expected=%0d",
             tag, obs, exp_v);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_strobe(input string tag);
    int k = 0;
    while (strobe !== 1'b1 && k < 50) begin
      tick();
      k++;
    end
    chk({tag, "_strobe"}, int'(strobe), 1);
  endtask

  task automatic expect_sample(input string tag,
                               input int v);
    wait_strobe(tag);
    tick();
    chk(tag, int'(ubit), v);
  endtask

  task automatic wait_busy(input logic v, input string tag);
    int k = 0;
    while (busy !== v && k < 400) begin
      tick();
      k++;
    end
    chk(tag, int'(busy), int'(v));
  endtask

  task automatic push(input int inc, input int dur,
                      output bit ok);
    cif.cmd_valid     = 1'b1;
    cif.cmd_phase_inc = PW'(inc);
    cif.cmd_duration  = DW'(dur);
    #1;
    ok = cif.cmd_ready;
    tick();
    cif.cmd_valid = 1'b0;
  endtask

  initial begin
    bit a;
    int n_acc;
    int base;
    int bad;
    int sc;
    int k;
    int vals[10] = '{0, 2, 4, 6, 8, 10, 12, 14, 15, 13};
    int incs[5]  = '{16, 32, 48, 80, 96};
    int lasts[5] = '{2, 4, 6, 10, 12};

    cif.cmd_valid     = 1'b0;
    cif.cmd_phase_inc = '0;
    cif.cmd_duration  = '0;

    // reset state
    tick(3);
    chk("rst_volt", int'(ubit), 8);
    chk("rst_busy", int'(busy), 0);
    chk("rst_strobe", int'(strobe), 0);
    chk("rst_done", int'(note_done), 0);
    chk("rst_ready", int'(cif.cmd_ready), 0);
    rst_n = 1'b1;
    #1;
    chk("ready_after_rst", int'(cif.cmd_ready), 1);

    // idle: strobe every 4 cycles, first at cycle 4
    for (int i = 1; i <= 20; i++) begin
      tick();
      chk("idle_strobe", int'(strobe), int'(i % 4 == 0));
      chk("idle_volt", int'(ubit), 8);
      chk("idle_busy", int'(busy), 0);
    end

    // single note
    push(16, 10, a);
    chk("single_acc", int'(a), 1);
    wait_busy(1'b1, "single_load");
    tick();
    for (int i = 0; i < 10; i++)
      expect_sample("single_s", vals[i]);
    chk("single_done", int'(note_done), 1);
    expect_sample("single_gap0", 8);
    chk("single_gap_busy", int'(busy), 1);
    expect_sample("single_gap1", 8);
    chk("single_idle", int'(busy), 0);
    chk("single_done_cnt", done_cnt, 1);

    // back-pressure: 5 back-to-back pushes, 6th refused
    done_log.delete();
    base  = done_cnt;
    n_acc = 0;
    for (int i = 0; i < 5; i++) begin
      push(incs[i], 2, a);
      n_acc += int'(a);
    end
    chk("bp_accepted", n_acc, 5);
    chk("bp_full_ready", int'(cif.cmd_ready), 0);
    push(112, 2, a);
    chk("bp_refused", int'(a), 0);
    wait_busy(1'b0, "bp_idle");
    chk("bp_notes", done_cnt - base, 5);
    chk("bp_log_size", done_log.size(), 5);
    for (int i = 0; i < 5; i++)
      chk("bp_order",
          (i < done_log.size()) ? done_log[i] : -1,
          lasts[i]);

    // zero duration then a rest
    done_log.delete();
    base = done_cnt;
    push(16, 0, a);
    push(0, 3, a);
    chk("zr_load", int'(busy), 1);
    tick();
    chk("zr_done0", int'(note_done), 1);
    chk("zr_volt0", int'(ubit), 8);
    bad = 0;
    sc  = int'(strobe);
    k   = 0;
    do begin
      tick();
      k++;
      if (ubit !== 4'd8) bad++;
      if (note_done !== 1'b1) sc += int'(strobe);
    end while (note_done !== 1'b1 && k < 100);
    chk("zr_done1", int'(note_done), 1);
    chk("zr_strobes", sc, 5);
    wait_busy(1'b0, "zr_idle");
    chk("zr_volt_flat", bad, 0);
    chk("zr_notes", done_cnt - base, 2);

    // phase wrap-around
    push(255, 4, a);
    wait_busy(1'b1, "wrap_load");
    tick();
    for (int i = 0; i < 4; i++)
      expect_sample("wrap_s", 0);
    chk("wrap_done", int'(note_done), 1);
    wait_busy(1'b0, "wrap_idle");

    // flush mid-note with two queued
    base = done_cnt;
    push(16, 10, a);
    push(32, 5, a);
    push(48, 5, a);
    expect_sample("fl_s0", 0);
    expect_sample("fl_s1", 2);
    expect_sample("fl_s2", 4);
    flush = 1'b1;
    cif.cmd_valid     = 1'b1;
    cif.cmd_phase_inc = PW'(112);
    cif.cmd_duration  = DW'(3);
    #1;
    chk("fl_ready", int'(cif.cmd_ready), 0);
    tick();
    flush = 1'b0;
    cif.cmd_valid = 1'b0;
    chk("fl_volt", int'(ubit), 8);
    chk("fl_busy", int'(busy), 0);
    chk("fl_done", int'(note_done), 0);
    tick();
    chk("fl_pre_keep0", int'(strobe), 0);
    tick();
    chk("fl_pre_keep1", int'(strobe), 1);
    tick(40);
    chk("fl_stay_idle", int'(busy), 0);
    chk("fl_no_done", done_cnt - base, 0);

    // reset mid-note with two queued
    push(16, 10, a);
    push(32, 5, a);
    push(48, 5, a);
    expect_sample("rm_s0", 0);
    expect_sample("rm_s1", 2);
    expect_sample("rm_s2", 4);
    rst_n = 1'b0;
    tick();
    chk("rm_volt", int'(ubit), 8);
    chk("rm_busy", int'(busy), 0);
    chk("rm_done", int'(note_done), 0);
    chk("rm_strobe", int'(strobe), 0);
    chk("rm_ready", int'(cif.cmd_ready), 0);
    rst_n = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk("rm_pre_restart", int'(strobe), int'(i == 4));
    end
    tick(40);
    chk("rm_stay_idle", int'(busy), 0);
    chk("rm_no_done", done_cnt - base, 0);

    $display("Result: errors=%0d of %0d checks",
             errs, checks);
    $finish;
  end

endmodule

// File: doc/pwm_note_sequencer.md
Name: pwm_note_sequencer

Overview:
- Command-driven controller that feeds the `ubit_voltage` input of the existing PWM output stage.
- Queues note commands, each a phase increment plus a duration in samples.
- Plays queued notes in order using a sample-rate prescaler and a phase accumulator, with a fixed silent gap between notes.
- Produces a registered triangle-wave voltage word that the PWM stage converts to a pin level.

Parameters:
- NBITRES, 12, width of the output voltage word; must match the PWM stage's nBitRes.
- PRESCALE, 1024, clocks per audio sample; minimum 2.
- PHASE_W, 24, phase accumulator and increment width; must be at least NBITRES+1.
- DUR_W, 16, width of the note duration field, in samples.
- FIFO_DEPTH, 4, command queue depth; power of 2.
- GAP_SAMPLES, 64, silent samples inserted after every note; 0 means no gap.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  synchronous, active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  queue can accept a command.
- cmd_phase_inc  in  PHASE_W  per-sample phase step; 0 means a rest (silence).
- cmd_duration  in  DUR_W  note length in samples.
- flush  in  1  abort the current note and empty the queue.
- ubit_voltage  out  NBITRES  voltage word to the PWM stage.
- sample_strobe  out  1  one-cycle pulse at each sample tick.
- busy  out  1  high whenever the state is not IDLE.
- note_done  out  1  one-cycle pulse when a note finishes.

Behaviour:
- Reset (rst_n=0 at a posedge):
  - Queue emptied, accumulator cleared, prescaler count cleared, state IDLE.
  - ubit_voltage = MID = 2^(NBITRES-1).
  - sample_strobe=0, note_done=0, busy=0.
  - cmd_ready=0 during reset; it is 1 from the first cycle after reset.
- Prescaler:
  - Free-running counter 0..PRESCALE-1; runs in every state.
  - sample_strobe is registered and is high in the cycle after the count equals PRESCALE-1.
  - The first strobe occurs PRESCALE cycles after reset release.
- Queue:
  - Depth FIFO_DEPTH; cmd_ready = !full.
  - A push happens on cmd_valid && cmd_ready.
  - In a cycle with a simultaneous pop, a full queue still refuses the push.
  - Push and pop in the same cycle on a non-full queue keeps the count unchanged.
- States:
  - IDLE: ubit_voltage = MID. If the queue is non-empty, go to LOAD.
  - LOAD (1 cycle):
    - Pop the head into inc_reg / remaining; clear the accumulator.
    - If duration = 0: pulse note_done and go to GAP, or to IDLE if GAP_SAMPLES = 0.
    - Otherwise go to PLAY.
  - PLAY: on each sample_strobe:
    - ubit_voltage <= tri(acc); acc <= acc + inc_reg (modulo 2^PHASE_W); remaining <= remaining - 1.
    - The strobe on which remaining reaches 0 is the last PLAY sample: pulse note_done next cycle and go to GAP, or to IDLE if GAP_SAMPLES = 0.
  - GAP:
    - ubit_voltage = MID; count GAP_SAMPLES strobes.
    - Then go to LOAD if the queue is non-empty, else IDLE.
- Triangle function:
  - p = acc[PHASE_W-1 : PHASE_W-NBITRES-1], i.e. NBITRES+1 bits.
  - tri = p[NBITRES-1:0] if p[NBITRES]=0, else ~p[NBITRES-1:0].
  - Output range is 0..2^NBITRES-1.
- Rests:
  - inc = 0 gives tri(0) = 0.
  - The block substitutes MID for the whole note; the duration is still honoured.
- Latency:
  - A command pushed into an empty queue while IDLE reaches LOAD 2 cycles after acceptance.
  - Its first voltage update lands on the first strobe after entering PLAY.
- ubit_voltage changes only on strobe cycles, or at the IDLE/GAP/flush transitions to MID.
- flush (highest priority below reset):
  - Queue cleared, state IDLE, acc=0, ubit_voltage=MID next cycle.
  - A push offered in the flush cycle is dropped; cmd_ready=0 during flush.
  - No note_done is generated.
  - The prescaler is not reset.
- Reset mid-note: identical to the power-up reset values.

Test Plan (bench params: NBITRES=4, PHASE_W=8, PRESCALE=4, FIFO_DEPTH=4, GAP_SAMPLES=2):
- Reset and idle: release rst_n, hold for 20 cycles with no commands -> ubit_voltage=8 throughout; busy=0; sample_strobe every 4 cycles, first at cycle 4.
- Single note: push inc=16, dur=10 -> on successive strobes ubit_voltage = 0,2,4,6,8,10,12,14,15,13; one note_done pulse; then 2 strobes at 8; then IDLE with busy=0.
- Back-pressure: push 5 commands back-to-back while IDLE -> the 5th sees cmd_ready=0 only if 4 remain queued; all accepted notes play in order; the observed note_done count equals the number of accepted commands.
- Zero duration and rest: push dur=0, then inc=0 dur=3 -> first note_done within 2 cycles of LOAD with no voltage change; then 3 strobes at 8; second note_done.
- Wrap-around: inc=255, dur=4 -> acc sequence 0,255,254,253 gives tri = 0,0,0,0 (top bits 00000, 11111→0, 11111→0, 11111→0); acc wraps without error.
- Flush and reset mid-note: flush during the 3rd sample of a 10-sample note with 2 queued -> next cycle ubit_voltage=8, busy=0, queue empty, no note_done. Repeat with rst_n=0 instead -> same outputs, prescaler restarted.
